// File: rtl/dest_strobe_responder.sv
// Destination-side strobe/stall responder: accepts and acks strobes, counts them, flags overruns.
// Optional WAIT_RDY timeout is enabled by defining DEST_RESP_TIMEOUT_EN.
module dest_strobe_responder #(
   parameter int unsigned PULSE_LIMIT    = 5,
   parameter int unsigned ACK_CYCLES     = 2,
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic             i_dest_clk,
   input  logic             i_dest_reset,
   input  logic             i_dest_strobe,
   input  logic             i_consumer_ready,
   input  logic             i_count_clr,
   output logic             o_dest_stall,
   output logic             o_strobe_valid,
   output logic [CNT_W-1:0] o_pulse_count,
   output logic             o_limit_reached,
   output logic             o_overrun_err,
   output logic             o_timeout_err
);

   localparam int unsigned      ACK_W    = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(PULSE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_RDY = 2'd1,
      S_ACK      = 2'd2
   } state_t;

   if (ACK_CYCLES < 1 || TIMEOUT_CYCLES < 1 || PULSE_LIMIT < 1) begin : g_bad_param
      $error("dest_strobe_responder: ACK_CYCLES, TIMEOUT_CYCLES and PULSE_LIMIT must be >= 1");
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   state_t             r_state;
   logic [ACK_W-1:0]   r_ack_cnt;
   logic               r_dest_stall;
   logic               r_strobe_valid;
   logic [CNT_W-1:0]   r_pulse_count;
   logic               r_limit_reached;
   logic               r_overrun_err;

   logic               w_accept;
   logic               w_overrun;
   logic [CNT_W-1:0]   w_cnt_base;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_timeout_evt;

`ifdef DEST_RESP_TIMEOUT_EN
   localparam int unsigned      TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] r_wait_cnt;
   logic             r_timeout_err;

   assign w_timeout_evt = (r_state == S_WAIT_RDY) && !i_consumer_ready && (r_wait_cnt == TMO_LAST);

   // Consecutive not-ready WAIT_RDY cycles; restarts from zero on every entry into WAIT_RDY.
   always_ff @(posedge i_dest_clk) begin
      if (i_dest_reset) begin
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= (i_count_clr ? 1'b0 : r_timeout_err) | w_timeout_evt;
         if (r_state == S_WAIT_RDY) begin
            r_wait_cnt <= r_wait_cnt + TMO_W'(1);
         end else begin
            r_wait_cnt <= '0;
         end
      end
   end

   assign o_timeout_err = r_timeout_err;
`else
   assign w_timeout_evt = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   // Strobe classification and the next pulse count (clear applies before the increment).
   always_comb begin
      w_accept   = i_dest_strobe && (r_state == S_IDLE);
      w_overrun  = i_dest_strobe && (r_state != S_IDLE);
      w_cnt_base = i_count_clr ? '0 : r_pulse_count;
      if (w_accept) begin
         w_cnt_next = sat_inc(w_cnt_base);
      end else begin
         w_cnt_next = w_cnt_base;
      end
   end

   // Handshake FSM with registered stall/valid outputs plus the counters and sticky flags.
   always_ff @(posedge i_dest_clk) begin
      if (i_dest_reset) begin
         r_state         <= S_IDLE;
         r_ack_cnt       <= '0;
         r_dest_stall    <= 1'b1;
         r_strobe_valid  <= 1'b0;
         r_pulse_count   <= '0;
         r_limit_reached <= 1'b0;
         r_overrun_err   <= 1'b0;
      end else begin
         r_strobe_valid  <= w_accept;
         r_pulse_count   <= w_cnt_next;
         r_limit_reached <= (w_cnt_next >= LIMIT);
         r_overrun_err   <= (i_count_clr ? 1'b0 : r_overrun_err) | w_overrun;
         case (r_state)
            S_IDLE: begin
               r_ack_cnt <= '0;
               if (w_accept && i_consumer_ready) begin
                  r_state      <= S_ACK;
                  r_dest_stall <= 1'b0;
               end else if (w_accept) begin
                  r_state      <= S_WAIT_RDY;
                  r_dest_stall <= 1'b1;
               end else begin
                  r_state      <= S_IDLE;
                  r_dest_stall <= 1'b1;
               end
            end
            S_WAIT_RDY: begin
               r_ack_cnt <= '0;
               if (i_consumer_ready || w_timeout_evt) begin
                  r_state      <= S_ACK;
                  r_dest_stall <= 1'b0;
               end else begin
                  r_state      <= S_WAIT_RDY;
                  r_dest_stall <= 1'b1;
               end
            end
            S_ACK: begin
               // The last low cycle hands back to IDLE so the stall rises on the same edge.
               if (r_ack_cnt == ACK_LAST) begin
                  r_state      <= S_IDLE;
                  r_ack_cnt    <= '0;
                  r_dest_stall <= 1'b1;
               end else begin
                  r_state      <= S_ACK;
                  r_ack_cnt    <= r_ack_cnt + ACK_W'(1);
                  r_dest_stall <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_ack_cnt    <= '0;
               r_dest_stall <= 1'b1;
            end
         endcase
      end
   end

   assign o_dest_stall    = r_dest_stall;
   assign o_strobe_valid  = r_strobe_valid;
   assign o_pulse_count   = r_pulse_count;
   assign o_limit_reached = r_limit_reached;
   assign o_overrun_err   = r_overrun_err;

endmodule

// File: tb/tb_dest_strobe_responder.sv
// Bench for dest_strobe_responder: directed scenarios then random stimulus against a cycle model.
// Two instances share stimulus: default widths and CNT_W=3 for saturation.
module tb_dest_strobe_responder;

   localparam int ACKC = 2;
   localparam int TMO  = 4;
   localparam int LIM  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       strobe = 1'b0;
   logic       ready = 1'b0;
   logic       clr = 1'b0;

   logic       stall8, sv8, lim8, ovr8, tmo8;
   logic [7:0] cnt8;
   logic       stall3, sv3, lim3, ovr3, tmo3;
   logic [2:0] cnt3;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_ack_left = 0;
   bit m_wait = 1'b0;
   int m_wcnt = 0;
   int m_cnt8 = 0;
   int m_cnt3 = 0;
   bit m_ovr = 1'b0;
   bit m_tmo = 1'b0;
   bit m_sv = 1'b0;

   always #5 clk = ~clk;

   dest_strobe_responder #(.PULSE_LIMIT(LIM), .ACK_CYCLES(ACKC), .CNT_W(8), .TIMEOUT_CYCLES(TMO)) u_dut8 (
      .i_dest_clk(clk), .i_dest_reset(rst), .i_dest_strobe(strobe), .i_consumer_ready(ready),
      .i_count_clr(clr), .o_dest_stall(stall8), .o_strobe_valid(sv8), .o_pulse_count(cnt8),
      .o_limit_reached(lim8), .o_overrun_err(ovr8), .o_timeout_err(tmo8));

   dest_strobe_responder #(.PULSE_LIMIT(LIM), .ACK_CYCLES(ACKC), .CNT_W(3), .TIMEOUT_CYCLES(TMO)) u_dut3 (
      .i_dest_clk(clk), .i_dest_reset(rst), .i_dest_strobe(strobe), .i_consumer_ready(ready),
      .i_count_clr(clr), .o_dest_stall(stall3), .o_strobe_valid(sv3), .o_pulse_count(cnt3),
      .o_limit_reached(lim3), .o_overrun_err(ovr3), .o_timeout_err(tmo3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit s, input bit r, input bit c, input bit x);
      bit idle;
      bit acc;
      if (x) begin
         m_ack_left = 0; m_wait = 1'b0; m_wcnt = 0;
         m_cnt8 = 0; m_cnt3 = 0; m_ovr = 1'b0; m_tmo = 1'b0; m_sv = 1'b0;
      end else begin
         idle = !m_wait && (m_ack_left == 0);
         acc  = s && idle;
         if (c) begin
            m_cnt8 = 0; m_cnt3 = 0; m_ovr = 1'b0; m_tmo = 1'b0;
         end
         if (acc) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt3 < 7) m_cnt3++;
         end
         if (s && !idle) m_ovr = 1'b1;
         m_sv = acc;
         if (idle) begin
            if (acc && r) m_ack_left = ACKC;
            else if (acc) begin m_wait = 1'b1; m_wcnt = 0; end
         end else if (m_wait) begin
            if (r) begin
               m_wait = 1'b0; m_ack_left = ACKC;
            end
`ifdef DEST_RESP_TIMEOUT_EN
            else begin
               m_wcnt++;
               if (m_wcnt == TMO) begin
                  m_wait = 1'b0; m_ack_left = ACKC; m_tmo = 1'b1;
               end
            end
`endif
         end else begin
            m_ack_left--;
         end
      end
   endtask

   // one clock: drive inputs, update model at the edge, check outputs 1 time unit later
   task automatic cyc(input bit s, input bit r, input bit c, input bit x);
      strobe = s; ready = r; clr = c; rst = x;
      @(posedge clk);
      model_step(s, r, c, x);
      #1;
      chk("stall8", stall8, (m_ack_left == 0));
      chk("valid8", sv8, m_sv);
      chk("count8", cnt8, m_cnt8);
      chk("limit8", lim8, (m_cnt8 >= LIM));
      chk("overrun8", ovr8, m_ovr);
      chk("timeout8", tmo8, m_tmo);
      chk("stall3", stall3, (m_ack_left == 0));
      chk("count3", cnt3, m_cnt3);
      chk("limit3", lim3, (m_cnt3 >= LIM));
      chk("overrun3", ovr3, m_ovr);
   endtask

   initial begin
      int lows;
      // reset state
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("rst_stall", stall8, 1);
      chk("rst_count", cnt8, 0);
      chk("rst_valid", sv8, 0);
      chk("rst_flags", {lim8, ovr8, tmo8}, 0);

      // five strobes with ready high, spaced 10 cycles
      for (int k = 0; k < 5; k++) begin
         cyc(1, 1, 0, 0);
         lows = (stall8 == 1'b0) ? 1 : 0;
         for (int j = 0; j < 9; j++) begin
            cyc(0, 1, 0, 0);
            if (stall8 == 1'b0) lows++;
         end
         chk("ack_len", lows, ACKC);
      end
      chk("count5", cnt8, 5);
      chk("limit5", lim8, 1);

      // strobe while not ready, ready raised 7 cycles later
      cyc(0, 1, 1, 0);
      cyc(1, 0, 0, 0);
      for (int j = 0; j < 7; j++) cyc(0, 0, 0, 0);
      for (int j = 0; j < 5; j++) cyc(0, 1, 0, 0);
      chk("wait_count", cnt8, 1);
      chk("wait_ovr", ovr8, 0);

      // second strobe during ACK is an overrun; clear afterwards
      cyc(0, 1, 1, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      for (int j = 0; j < 4; j++) cyc(0, 1, 0, 0);
      chk("ovr_count", cnt8, 1);
      chk("ovr_flag", ovr8, 1);
      cyc(0, 1, 1, 0);
      chk("clr_all", {cnt8, lim8, ovr8}, 0);

      // nine strobes: 3-bit counter saturates at 7
      for (int k = 0; k < 9; k++) begin
         cyc(1, 1, 0, 0);
         for (int j = 0; j < 3; j++) cyc(0, 1, 0, 0);
      end
      chk("sat3", cnt3, 7);
      chk("cnt9", cnt8, 9);
      cyc(1, 1, 1, 0);
      chk("clr_strobe3", cnt3, 1);
      chk("clr_strobe8", cnt8, 1);
      for (int j = 0; j < 3; j++) cyc(0, 1, 0, 0);

      // reset in the middle of an ack
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 1);
      chk("rst_mid_stall", stall8, 1);
      chk("rst_mid_count", cnt8, 0);
      cyc(0, 0, 0, 0);

      // ready held low: timeout forces the ack when enabled
      cyc(1, 0, 0, 0);
      for (int j = 0; j < 6; j++) cyc(0, 0, 0, 0);
`ifdef DEST_RESP_TIMEOUT_EN
      chk("timeout_flag", tmo8, 1);
`else
      chk("no_timeout", tmo8, 0);
      chk("still_waiting", stall8, 1);
`endif
      for (int j = 0; j < 4; j++) cyc(0, 1, 0, 0);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 29) == 0), ($urandom_range(0, 59) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
